reg_wr_arb: RTL and testbench

REG_WR_ARB -- requirements
Module: reg_wr_arb

---
 rtl/reg_wr_arb.sv | 138 +++++++++++++
 tb/tb_reg_wr_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_wr_arb.sv
// reg_wr_arb: four requesters compete for one shared N-bit register.
// The winner's data slice is loaded into q_N on its grant edge. A grant is
// followed by HOLD idle cycles before the next grant can be issued.
//
// Build option: define REG_WR_ARB_FIXED_PRI_EN for fixed priority
// (requester 0 highest). When it is undefined, a round-robin pointer is used.
//
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   en     grant enable; while low, no new grant is issued
//   req    level request per requester (bit i = requester i)
//   d_in   requester data, slice i at [i*N +: N]
//   gnt    registered one-hot grant, 1-cycle pulse
//   q_N    shared register contents
//   q_vld  1-cycle pulse; q_N was updated this cycle
//   busy   high whenever the FSM is not idle
module reg_wr_arb #(
  parameter int unsigned N    = 32,
  parameter int unsigned HOLD = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [3:0]     req,
  input  logic [4*N-1:0] d_in,
  output logic [3:0]     gnt,
  output logic [N-1:0]   q_N,
  output logic           q_vld,
  output logic           busy
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_HOLD} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [3:0]     gnt_d;
  logic [N-1:0]   q_d;
  logic           q_vld_d;
  logic           busy_d;
  logic           found;
  logic [1:0]     win;
`ifndef REG_WR_ARB_FIXED_PRI_EN
  logic [1:0]     ptr_q, ptr_d;
`endif

  // Winner search over the current request vector
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
`ifdef REG_WR_ARB_FIXED_PRI_EN
    // Scan from the lowest priority up, so requester 0 overrides the rest
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        win   = 2'(i);
      end
    end
`else
    // Scan starts at the pointer and wraps modulo 4
    for (int i = 0; i < 4; i++) begin
      if (!found && req[2'(ptr_q + 2'(i))]) begin
        found = 1'b1;
        win   = 2'(ptr_q + 2'(i));
      end
    end
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = 4'd0;
    q_vld_d = 1'b0;
    q_d     = q_N;
`ifndef REG_WR_ARB_FIXED_PRI_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (en && found) begin
          state_d = S_WRITE;
          gnt_d   = 4'b0001 << win;
          q_vld_d = 1'b1;
          q_d     = d_in[32'(win)*N +: N];
`ifndef REG_WR_ARB_FIXED_PRI_EN
          ptr_d   = win + 2'd1;
`endif
        end
      end
      S_WRITE: begin
        if (HOLD > 0) begin
          state_d = S_HOLD;
          cnt_d   = 4'(HOLD - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        // Counter holds the number of HOLD cycles still to come
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      gnt     <= 4'd0;
      q_N     <= '0;
      q_vld   <= 1'b0;
      busy    <= 1'b0;
`ifndef REG_WR_ARB_FIXED_PRI_EN
      ptr_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      q_N     <= q_d;
      q_vld   <= q_vld_d;
      busy    <= busy_d;
`ifndef REG_WR_ARB_FIXED_PRI_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg_wr_arb.sv
// Testbench for reg_wr_arb. Two instances (HOLD=0 and HOLD=3) share the same
// stimulus. A cycle-counting reference model predicts the outputs of both
// instances. Directed phases pin the model with literal expectations, and a
// random phase follows.
module tb_reg_wr_arb;

  localparam int N = 32;

  logic           clk;
  logic           rst;
  logic           en;
  logic [3:0]     req;
  logic [4*N-1:0] d_in;
  logic [3:0]     gnt0, gnt1;
  logic [N-1:0]   q0, q1;
  logic           vld0, vld1, busy0, busy1;

  reg_wr_arb #(.N(N), .HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .req(req), .d_in(d_in),
    .gnt(gnt0), .q_N(q0), .q_vld(vld0), .busy(busy0)
  );

  reg_wr_arb #(.N(N), .HOLD(3)) dut1 (
    .clk(clk), .rst(rst), .en(en), .req(req), .d_in(d_in),
    .gnt(gnt1), .q_N(q1), .q_vld(vld1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: per instance, count the busy cycles left after a grant
  int           hold_v [2] = '{0, 3};
  int           m_left [2];
  int           m_ptr  [2];
  logic [3:0]   m_gnt  [2];
  logic         m_vld  [2];
  logic         m_busy [2];
  logic [N-1:0] m_q    [2];
  bit           started = 1'b0;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int j = 0; j < 4; j++) begin
      if (r[(p + j) % 4]) return (p + j) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    logic [3:0]     r;
    logic           e, rs;
    logic [4*N-1:0] d;
    int             w;
    r = req; e = en; rs = rst; d = d_in;
    for (int k = 0; k < 2; k++) begin
      if (rs) begin
        m_left[k] = 0; m_ptr[k] = 0; m_gnt[k] = 4'd0;
        m_vld[k] = 1'b0; m_busy[k] = 1'b0; m_q[k] = '0;
      end else if (m_left[k] > 0) begin
        m_left[k]--;
        m_gnt[k]  = 4'd0;
        m_vld[k]  = 1'b0;
        m_busy[k] = (m_left[k] > 0);
      end else begin
`ifdef REG_WR_ARB_FIXED_PRI_EN
        w = e ? pick(r, 0) : -1;
`else
        w = e ? pick(r, m_ptr[k]) : -1;
`endif
        if (w >= 0) begin
          m_gnt[k]  = 4'(1 << w);
          m_q[k]    = d[w*N +: N];
          m_vld[k]  = 1'b1;
          m_busy[k] = 1'b1;
          m_left[k] = 1 + hold_v[k];
          m_ptr[k]  = (w + 1) % 4;
        end else begin
          m_gnt[k]  = 4'd0;
          m_vld[k]  = 1'b0;
          m_busy[k] = 1'b0;
        end
      end
    end
    if (rs) started = 1'b1;
    #1;
    if (started) begin
      chk("m_gnt0",  64'(gnt0),  64'(m_gnt[0]));
      chk("m_q0",    64'(q0),    64'(m_q[0]));
      chk("m_vld0",  64'(vld0),  64'(m_vld[0]));
      chk("m_busy0", 64'(busy0), 64'(m_busy[0]));
      chk("m_gnt1",  64'(gnt1),  64'(m_gnt[1]));
      chk("m_q1",    64'(q1),    64'(m_q[1]));
      chk("m_vld1",  64'(vld1),  64'(m_vld[1]));
      chk("m_busy1", 64'(busy1), 64'(m_busy[1]));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [3:0] exp_c0 [10];
  logic [3:0] exp_c1 [10];
  logic [3:0] exp_d1 [12];
  int         busy_cnt;

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'd0; d_in = '0;
`ifdef REG_WR_ARB_FIXED_PRI_EN
    exp_c0 = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0};
    exp_c1 = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    exp_d1 = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
`else
    exp_c0 = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
    exp_c1 = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
    exp_d1 = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
`endif
    step(2);

    // Reset and idle: no activity with req=0
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("idle_gnt",  64'(gnt0),  64'h0);
      chk("idle_q",    64'(q0),    64'h0);
      chk("idle_busy", 64'(busy0), 64'h0);
      chk("idle_vld",  64'(vld0 | vld1), 64'h0);
    end

    // Single request from requester 2
    for (int i = 0; i < 4; i++) d_in[i*N +: N] = $urandom;
    d_in[2*N +: N] = 32'hDEADBEEF;
    req = 4'b0100;
    step(1);
    chk("single_gnt",  64'(gnt0),  64'h4);
    chk("single_q",    64'(q0),    64'hDEADBEEF);
    chk("single_vld",  64'(vld0),  64'h1);
    chk("single_busy", 64'(busy0), 64'h1);
    req = 4'd0;
    step(1);
    chk("single_busy_after", 64'(busy0), 64'h0);
    chk("single_q_kept",     64'(q0),    64'hDEADBEEF);
    step(4);

    // Fairness with all four requesting
    rst = 1'b1; step(1); rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk($sformatf("fair0_%0d", i), 64'(gnt0), 64'(exp_c0[i]));
      chk($sformatf("fair1_%0d", i), 64'(gnt1), 64'(exp_c1[i]));
    end

    // HOLD spacing with two requesters
    rst = 1'b1; step(1); rst = 1'b0;
    req = 4'b0011;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk($sformatf("hold_gnt_%0d", i), 64'(gnt1), 64'(exp_d1[i]));
      if (i < 10 && busy1) busy_cnt++;
    end
    chk("hold_busy_cycles", 64'(busy_cnt), 64'd8);

    // Enable gating
    rst = 1'b1; step(1); rst = 1'b0;
    en = 1'b0; req = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("gated_gnt", 64'(gnt0), 64'h0);
    end
    en = 1'b1;
    step(1);
    chk("ungated_gnt", 64'(gnt0), 64'h8);

    // Reset during a WRITE cycle
    req = 4'd0;
    step(1);
    req = 4'b0010;
    step(1);
    chk("pre_rst_gnt", 64'(gnt0), 64'h2);
    rst = 1'b1; req = 4'd0;
    step(1);
    chk("rst_q",    64'(q0),    64'h0);
    chk("rst_busy", 64'(busy0), 64'h0);
    chk("rst_gnt",  64'(gnt0),  64'h0);
    rst = 1'b0; req = 4'b1111;
    step(1);
    chk("post_rst_gnt0", 64'(gnt0), 64'h1);
    chk("post_rst_gnt1", 64'(gnt1), 64'h1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      req = 4'($urandom);
      en  = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 49) == 0);
      for (int s = 0; s < 4; s++) d_in[s*N +: N] = $urandom;
      step(1);
    end
    rst = 1'b0; req = 4'd0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
